// File: rtl/micro_core.sv
// Accumulator micro-core: fetch/execute/halt sequencer, 16-entry register file,
// ALU with zero and carry flags, and conditional jumps through register targets.
module micro_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int NREGS  = 16
) (
    input  logic              clk,
    input  logic              CLB,
    input  logic [7:0]        INST,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [PC_W-1:0]   PC,
    output logic [DATA_W-1:0] ACC,
    output logic              z_flag,
    output logic              c_flag,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        ir;
    logic [DATA_W-1:0] regs [NREGS];
    logic [3:0]        opcode;
    logic [3:0]        n;
    logic [DATA_W-1:0] operand;
    logic [PC_W-1:0]   jump_target;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;

    logic [DATA_W-1:0] acc_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic              z_nxt;
    logic              c_nxt;
    logic              acc_we;
    logic              reg_we;

    assign opcode  = ir[7:4];
    assign n       = ir[3:0];
    assign operand = regs[n];
    // Size cast truncates a wide register or zero-extends a narrow one.
    assign jump_target = PC_W'(operand);
    // The extra top bit of diff is the unsigned borrow, i.e. ACC < R[n].
    assign sum  = {1'b0, ACC} + {1'b0, operand};
    assign diff = {1'b0, ACC} - {1'b0, operand};

    always_ff @(posedge clk) begin
        if (CLB) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:   if (inst_valid) state_nxt = EXEC;
            EXEC:    state_nxt = (opcode == 4'hF) ? HALT : FETCH;
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        inst_ready = (state == FETCH);
        halted     = (state == HALT);
    end

    // Conditional jumps read the flag registers, so they see pre-EXEC values.
    always_comb begin
        acc_nxt = ACC;
        c_nxt   = c_flag;
        pc_nxt  = PC + PC_W'(1);
        acc_we  = 1'b0;
        reg_we  = 1'b0;
        case (opcode)
            4'h0: ;
            4'h1: begin acc_nxt = DATA_W'(n);         acc_we = 1'b1; end
            4'h2: begin acc_nxt = operand;            acc_we = 1'b1; end
            4'h3: reg_we = 1'b1;
            4'h4: begin {c_nxt, acc_nxt} = sum;       acc_we = 1'b1; end
            4'h5: begin {c_nxt, acc_nxt} = diff;      acc_we = 1'b1; end
            4'h6: begin acc_nxt = ACC & operand;      acc_we = 1'b1; end
            4'h7: begin acc_nxt = ACC | operand;      acc_we = 1'b1; end
            4'h8: begin acc_nxt = ACC ^ operand;      acc_we = 1'b1; end
            4'h9: begin {c_nxt, acc_nxt} = {ACC, 1'b0}; acc_we = 1'b1; end
            4'hA: begin {acc_nxt, c_nxt} = {1'b0, ACC}; acc_we = 1'b1; end
            4'hB: pc_nxt = jump_target;
            4'hC: if (z_flag)  pc_nxt = jump_target;
            4'hD: if (c_flag)  pc_nxt = jump_target;
            4'hE: if (!z_flag) pc_nxt = jump_target;
            4'hF: pc_nxt = PC;
            default: ;
        endcase
        z_nxt = acc_we ? (acc_nxt == '0) : z_flag;
    end

    always_ff @(posedge clk) begin
        if (CLB) begin
            PC     <= '0;
            ACC    <= '0;
            z_flag <= 1'b0;
            c_flag <= 1'b0;
            ir     <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (state == FETCH && inst_valid) begin
                ir <= INST;
            end
            if (state == EXEC) begin
                PC     <= pc_nxt;
                ACC    <= acc_nxt;
                z_flag <= z_nxt;
                c_flag <= c_nxt;
                if (reg_we) begin
                    regs[n] <= ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_micro_core.sv
// Scoreboard bench for micro_core: each issued instruction queues its expected
// architectural state, and a monitor compares it when the instruction retires.
module tb_micro_core;

    localparam int DATA_W = 8;
    localparam int PC_W   = 8;

    logic              clk = 1'b0;
    logic              CLB;
    logic [7:0]        INST;
    logic              inst_valid;
    logic              inst_ready;
    logic [PC_W-1:0]   PC;
    logic [DATA_W-1:0] ACC;
    logic              z_flag;
    logic              c_flag;
    logic              halted;

    typedef struct {
        logic [7:0] inst;
        logic [7:0] pc;
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic       ready;
        logic       halt;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    bit   monitor_en = 1'b0;
    bit   was_exec = 1'b0;

    micro_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(16)) dut (
        .clk        (clk),
        .CLB        (CLB),
        .INST       (INST),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .PC         (PC),
        .ACC        (ACC),
        .z_flag     (z_flag),
        .c_flag     (c_flag),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Queue the expected post-EXEC state, then spend one FETCH and one EXEC cycle.
    task automatic applyStimulus(input logic [7:0] inst, input logic [7:0] epc, input logic [7:0] eacc,
                                 input logic ez, input logic ec, input logic ehalt);
        exp_t e;
        e.inst = inst; e.pc = epc; e.acc = eacc; e.z = ez; e.c = ec;
        e.ready = !ehalt; e.halt = ehalt;
        checkOutput($sformatf("ready before issue %02h", inst), inst_ready, 1);
        expq.push_back(e);
        INST       = inst;
        inst_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // A negedge sample following one taken in EXEC shows a retired instruction.
    always @(negedge clk) begin
        if (monitor_en && was_exec) begin
            checkOutput("retire expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                mon_e = expq.pop_front();
                checkOutput($sformatf("pc after %02h", mon_e.inst), PC, mon_e.pc);
                checkOutput($sformatf("acc after %02h", mon_e.inst), ACC, mon_e.acc);
                checkOutput($sformatf("z,c after %02h", mon_e.inst), {z_flag, c_flag}, {mon_e.z, mon_e.c});
                checkOutput($sformatf("ready,halted after %02h", mon_e.inst), {inst_ready, halted},
                            {mon_e.ready, mon_e.halt});
            end
        end
        was_exec = monitor_en && (inst_ready === 1'b0) && (halted === 1'b0);
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        CLB = 1'b1; INST = 8'h00; inst_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 CLB = 1'b0;
        @(negedge clk);
        checkOutput("reset pc", PC, 0);
        checkOutput("reset acc", ACC, 0);
        checkOutput("reset z,c", {z_flag, c_flag}, 0);
        checkOutput("ready,halted after reset", {inst_ready, halted}, 2'b10);
        monitor_en = 1'b1;

        applyStimulus(8'h15, 8'h01, 8'h05, 0, 0, 0);
        applyStimulus(8'h31, 8'h02, 8'h05, 0, 0, 0);
        applyStimulus(8'h13, 8'h03, 8'h03, 0, 0, 0);
        applyStimulus(8'h41, 8'h04, 8'h08, 0, 0, 0);
        applyStimulus(8'h21, 8'h05, 8'h05, 0, 0, 0);
        applyStimulus(8'h19, 8'h06, 8'h09, 0, 0, 0);
        applyStimulus(8'h36, 8'h07, 8'h09, 0, 0, 0);
        applyStimulus(8'h26, 8'h08, 8'h09, 0, 0, 0);
        applyStimulus(8'h11, 8'h09, 8'h01, 0, 0, 0);
        applyStimulus(8'h33, 8'h0A, 8'h01, 0, 0, 0);
        applyStimulus(8'h10, 8'h0B, 8'h00, 1, 0, 0);
        applyStimulus(8'h53, 8'h0C, 8'hFF, 0, 1, 0);
        applyStimulus(8'h32, 8'h0D, 8'hFF, 0, 1, 0);
        applyStimulus(8'h11, 8'h0E, 8'h01, 0, 1, 0);
        applyStimulus(8'h42, 8'h0F, 8'h00, 1, 1, 0);
        applyStimulus(8'h11, 8'h10, 8'h01, 0, 1, 0);
        applyStimulus(8'h32, 8'h11, 8'h01, 0, 1, 0);
        applyStimulus(8'h10, 8'h12, 8'h00, 1, 1, 0);
        applyStimulus(8'h52, 8'h13, 8'hFF, 0, 1, 0);
        applyStimulus(8'h52, 8'h14, 8'hFE, 0, 0, 0);
        applyStimulus(8'h66, 8'h15, 8'h08, 0, 0, 0);
        applyStimulus(8'h71, 8'h16, 8'h0D, 0, 0, 0);
        applyStimulus(8'h86, 8'h17, 8'h04, 0, 0, 0);
        applyStimulus(8'h90, 8'h18, 8'h08, 0, 0, 0);
        applyStimulus(8'hA0, 8'h19, 8'h04, 0, 0, 0);
        applyStimulus(8'hA0, 8'h1A, 8'h02, 0, 0, 0);
        applyStimulus(8'hA0, 8'h1B, 8'h01, 0, 0, 0);
        applyStimulus(8'hA0, 8'h1C, 8'h00, 1, 1, 0);
        applyStimulus(8'h52, 8'h1D, 8'hFF, 0, 1, 0);
        applyStimulus(8'h90, 8'h1E, 8'hFE, 0, 1, 0);
        applyStimulus(8'h62, 8'h1F, 8'h00, 1, 1, 0);
        applyStimulus(8'h90, 8'h20, 8'h00, 1, 0, 0);
        applyStimulus(8'h18, 8'h21, 8'h08, 0, 0, 0);
        applyStimulus(8'h90, 8'h22, 8'h10, 0, 0, 0);
        applyStimulus(8'h90, 8'h23, 8'h20, 0, 0, 0);
        applyStimulus(8'h90, 8'h24, 8'h40, 0, 0, 0);
        applyStimulus(8'h90, 8'h25, 8'h80, 0, 0, 0);
        applyStimulus(8'h90, 8'h26, 8'h00, 1, 1, 0);
        applyStimulus(8'h18, 8'h27, 8'h08, 0, 1, 0);
        applyStimulus(8'h90, 8'h28, 8'h10, 0, 0, 0);
        applyStimulus(8'h90, 8'h29, 8'h20, 0, 0, 0);
        applyStimulus(8'h33, 8'h2A, 8'h20, 0, 0, 0);
        applyStimulus(8'hC3, 8'h2B, 8'h20, 0, 0, 0);
        applyStimulus(8'h10, 8'h2C, 8'h00, 1, 0, 0);
        applyStimulus(8'hC3, 8'h20, 8'h00, 1, 0, 0);
        applyStimulus(8'hE3, 8'h21, 8'h00, 1, 0, 0);
        applyStimulus(8'hD3, 8'h22, 8'h00, 1, 0, 0);
        applyStimulus(8'h52, 8'h23, 8'hFF, 0, 1, 0);
        applyStimulus(8'hD3, 8'h20, 8'hFF, 0, 1, 0);
        applyStimulus(8'hE3, 8'h20, 8'hFF, 0, 1, 0);
        applyStimulus(8'h35, 8'h21, 8'hFF, 0, 1, 0);
        applyStimulus(8'hB5, 8'hFF, 8'hFF, 0, 1, 0);
        applyStimulus(8'h00, 8'h00, 8'hFF, 0, 1, 0);
        applyStimulus(8'hB3, 8'h20, 8'hFF, 0, 1, 0);
        applyStimulus(8'hF0, 8'h20, 8'hFF, 0, 1, 1);

        INST = 8'h15;
        repeat (10) begin
            @(negedge clk);
            checkOutput("halt pc frozen", PC, 8'h20);
            checkOutput("halt acc frozen", ACC, 8'hFF);
            checkOutput("halt ready,halted", {inst_ready, halted}, 2'b01);
        end

        @(posedge clk); #1 CLB = 1'b1; inst_valid = 1'b0;
        @(posedge clk); #1 CLB = 1'b0;
        @(negedge clk);
        checkOutput("pc after halt reset", PC, 0);
        checkOutput("acc after halt reset", ACC, 0);
        checkOutput("z,c after halt reset", {z_flag, c_flag}, 0);
        checkOutput("ready,halted after halt reset", {inst_ready, halted}, 2'b10);

        applyStimulus(8'h17, 8'h01, 8'h07, 0, 0, 0);
        inst_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idle pc", PC, 8'h01);
            checkOutput("idle acc", ACC, 8'h07);
            checkOutput("idle z,c", {z_flag, c_flag}, 0);
            checkOutput("idle ready", inst_ready, 1);
        end

        expq.push_back('{inst: 8'h34, pc: 8'h00, acc: 8'h00, z: 1'b0, c: 1'b0, ready: 1'b1, halt: 1'b0});
        INST = 8'h34; inst_valid = 1'b1;
        @(posedge clk); #1 CLB = 1'b1; inst_valid = 1'b0;
        @(posedge clk); #1 CLB = 1'b0;

        applyStimulus(8'h24, 8'h01, 8'h00, 1, 0, 0);
        applyStimulus(8'h23, 8'h02, 8'h00, 1, 0, 0);
        applyStimulus(8'h25, 8'h03, 8'h00, 1, 0, 0);
        inst_valid = 1'b0;

        repeat (3) @(posedge clk);
        checkOutput("queue drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/micro_core.md
MICRO_CORE -- requirements
Module: micro_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning accumulator/register/ALU width (legal values 4..32).
REQ-002 SHALL have parameter PC_W, default 8, meaning program-counter width (legal values 4..16).
REQ-003 SHALL have parameter NREGS, default 16, meaning register-file depth; fixed at 16 because INST[3:0] addresses it.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port CLB, input, 1, meaning reset; synchronous and active-high.
REQ-006 SHALL have port INST, input, 8, meaning instruction byte: opcode INST[7:4], operand n = INST[3:0].
REQ-007 SHALL have port inst_valid, input, 1, meaning INST is valid this cycle.
REQ-008 SHALL have port inst_ready, output, 1, meaning core is in FETCH and will accept INST.
REQ-009 SHALL have port PC, output, PC_W, meaning address of the instruction being fetched or executed.
REQ-010 SHALL have port ACC, output, DATA_W, meaning accumulator value.
REQ-011 SHALL have ports z_flag and c_flag, output, 1 each, meaning zero flag and carry/borrow flag.
REQ-012 SHALL have port halted, output, 1, meaning core is in HALT.

Function
REQ-013 SHALL implement FSM states FETCH, EXEC, HALT; inst_ready = (state == FETCH).
REQ-014 In FETCH, a cycle with inst_valid=1 SHALL latch INST into IR and move to EXEC; with inst_valid=0, SHALL stay in FETCH with no state change.
REQ-015 EXEC SHALL last exactly one cycle, commit all results at its clock edge, and return to FETCH (HLT excepted); minimum throughput is one instruction per 2 cycles.
REQ-016 SHALL decode: 0 NOP; 1 LDI ACC=zext(n); 2 LDR ACC=R[n]; 3 STR R[n]=ACC; 4 ADD {C,ACC}=ACC+R[n]; 5 SUB ACC=ACC-R[n], C=(ACC<R[n]) unsigned.
REQ-017 SHALL decode: 6 AND, 7 OR, 8 XOR (ACC op R[n], C unchanged); 9 SHL {C,ACC}={ACC,0}; A SHR {ACC,C}={0,ACC}; n ignored for 9/A.
REQ-018 SHALL decode: B JMP PC=R[n]; C JZ, D JC, E JNZ (PC=R[n] if z_flag=1 / c_flag=1 / z_flag=0); F HLT.
REQ-019 Jump targets SHALL be R[n] truncated to PC_W when DATA_W>PC_W, and zero-extended when DATA_W<PC_W.
REQ-020 Conditional jumps SHALL test the flag values held before the EXEC edge.
REQ-021 In EXEC, PC SHALL become the jump target if the jump is taken, else PC+1 modulo 2^PC_W (wraps from all-ones to 0).
REQ-022 z_flag SHALL update to (new ACC == 0) on every ACC-writing opcode (1,2,4-A), and hold otherwise.
REQ-023 c_flag SHALL update only on opcodes 4, 5, 9 and A; all other opcodes SHALL leave it unchanged.
REQ-024 STR followed by LDR of the same register SHALL read the newly stored value (no stale read).
REQ-025 HLT SHALL move to HALT with PC unchanged; HALT SHALL hold all state, keep inst_ready=0 and halted=1, and be left only by reset.

Reset
REQ-026 CLB=1 at a clock edge SHALL set PC=0, ACC=0, z_flag=0, c_flag=0, all R[i]=0, IR=0, state=FETCH and halted=0, regardless of state.
REQ-027 CLB SHALL take priority over fetch and execute; reset during EXEC SHALL discard that instruction with no register, flag or PC write.
REQ-028 inst_ready SHALL be 1 in the first cycle after CLB deasserts.

Verification
REQ-029 Reset, then LDI 5; STR 1; LDI 3; ADD 1 with inst_valid always 1 -> ACC=8, z=0, c=0, R1=5, PC=4 after 8 cycles.
REQ-030 DATA_W=8: R2=0xFF, ACC=0x01, ADD 2 -> ACC=0x00, z=1, c=1; then SUB 2 with R2=0x01 -> ACC=0xFF, c=1, z=0.
REQ-031 inst_valid held low for 5 cycles in FETCH -> PC, ACC and flags unchanged, inst_ready=1 throughout, then normal execution resumes.
REQ-032 R3=0x20, z=1, JZ 3 -> PC=0x20; with z=0 -> PC=old PC+1; PC=0xFF executing NOP -> PC=0x00.
REQ-033 HLT -> halted=1, inst_ready=0, PC frozen over 10 cycles of inst_valid=1; CLB pulse -> PC=0, halted=0.
REQ-034 CLB asserted in the EXEC cycle of STR 4 (ACC=7) -> R4=0, ACC=0, state FETCH next cycle.
